gc_pad_responder: RTL and testbench
===================================

Name: gc_pad_responder

Overview:
- Emulates the controller side of the GameCube single-wire joybus.
- Decodes console commands on the data line and answers identify (0x00) and poll (0x40 xx yy) requests.
- Poll replies carry a 64-bit pad state, which is supplied by the I2C register bank upstream in the same FPGA.
- Drives the line open-drain, in the same way the I2C pad buffer handles SDA. Also exports the console's rumble request bit.

Parameters:
US_CYCLES, 25, clk cycles per microsecond; all protocol timing derives from it; minimum 4.
TURN_US, 4, microseconds of line-idle between the console stop bit and the first reply bit.
TIMEOUT_US, 64, line-high time mid-command after which a partial command is discarded.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
gc_in  input  1  raw joybus line level (asynchronous to clk)
gc_drive_low  output  1  1 = pull joybus line low; 0 = release (tristate at pad)
pad_state  input  64  reply payload for poll, MSB first (buttons, sticks, triggers)
rumble  output  1  bit 0 of the last valid poll's third byte
busy  output  1  high from first command falling edge until reply stop bit ends
poll_strobe  output  1  one-cycle pulse when a poll reply starts (pad_state snapshot taken)

Behaviour:
- Reset (asynchronous, active-low): gc_drive_low=0, rumble=0, busy=0, poll_strobe=0, FSM=IDLE, all counters 0. Reset asserted mid-reply releases the line immediately.
- gc_in passes through a 2-FF synchronizer plus falling-edge detect. Input latency is 2 clk.
- RX bit decode:
  - Each falling edge starts a bit.
  - Sample the synchronized line at 2*US_CYCLES after the edge: high = 1, low = 0.
  - Shift MSB-first into a 24-bit command register; count bits.
- Command framing:
  - After 8 bits with value 0x00, the next falling edge is the stop bit. Expected reply: 24 bits, 0x090000.
  - After 8 bits with value 0x40, collect 16 more bits, then the stop bit. Expected reply: 64 bits, pad_state.
  - Any other first byte → IGNORE state. Return to IDLE once the line has been high for TIMEOUT_US.
  - Stop bit accepted when the line returns high within 2*US_CYCLES of its falling edge. A longer low → IGNORE.
- States:
  - IDLE → RX on falling edge; busy goes high.
  - RX → STOP after the expected bit count.
  - RX/STOP → IGNORE on timeout or bad command.
  - STOP → TURN on valid stop bit. At this point the reply word is loaded: pad_state snapshot, or the ID constant. poll_strobe pulses for poll only, and rumble is updated from cmd[0].
  - TURN: wait TURN_US*US_CYCLES cycles → TX.
  - TX per bit, 4 us slot: drive low 1 us for a 1, 3 us for a 0, then release for the rest of the slot.
  - TX → TXSTOP after the last bit: drive low 2 us, release.
  - TXSTOP → IDLE; busy drops on the same cycle.
- Falling edges seen while in TURN, TX or TXSTOP are ignored; the block sees its own drive.
- pad_state changes after the snapshot do not affect the reply in progress (no tearing).
- A timer counts line-high time in RX and STOP. A falling edge resets it. At TIMEOUT_US*US_CYCLES: → IDLE, busy=0, command discarded, rumble unchanged.
- Widths:
  - Slot counter sized for 4*US_CYCLES.
  - Timeout counter sized for TIMEOUT_US*US_CYCLES.
  - Bit counter 7 bits: reply index 0..63, command 0..23.

Decomposition:
- Package gc_pkg holds:
  - CMD_ID = 8'h00
  - CMD_POLL = 8'h40
  - ID_REPLY = 24'h090000
  - state enum (IDLE, RX, STOP, IGNORE, TURN, TX, TXSTOP)
  - reply length constants 24 and 64
- One sub-module: gc_line_sync, the 2-FF synchronizer with falling-edge pulse output. It uses the same clk and the active-low asynchronous reset, which resets it to line-high.

Test Plan:
(All scenarios use US_CYCLES=4.)
- Identify: console model sends 0x00 + stop → after 4 us idle, DUT sends 24 bits decoding to 0x090000 + 2 us stop. busy falls, poll_strobe never pulses.
- Poll: pad_state=64'h0080_8080_8080_0000; console sends 0x400301 + stop → 64-bit reply equals that value; rumble=1; poll_strobe pulses once. Repeat with 0x400300 → rumble=0.
- Snapshot: change pad_state to all-ones 1 cycle after poll_strobe → reply still 64'h0080_8080_8080_0000.
- Unknown command 0x41 → gc_drive_low stays 0; busy drops TIMEOUT_US after the last edge. A following valid identify is answered normally.
- Truncated poll: console stops after 12 bits → no reply; return to IDLE after timeout; rumble unchanged.
- Reset mid-reply: assert reset while gc_drive_low=1 → gc_drive_low=0 the same instant, all outputs at reset values; the next poll is answered correctly.

Source files
------------

// File: rtl/gc_pkg.sv
// ---------------------------------------------------------------------------
// gc_pkg
// Shared constants and types for the GameCube joybus pad responder.
//   CMD_ID / CMD_POLL   : console command bytes that get an answer
//   ID_REPLY            : fixed 24-bit identify answer (standard controller)
//   *_BITS              : command and reply lengths, sized for the 7-bit
//                         bit counter
//   gc_state_e          : responder FSM states
//   reply_word()        : left-aligned reply shift word for either command
// ---------------------------------------------------------------------------
package gc_pkg;

   localparam logic [7:0]  CMD_ID          = 8'h00;
   localparam logic [7:0]  CMD_POLL        = 8'h40;
   localparam logic [23:0] ID_REPLY        = 24'h090000;

   localparam logic [6:0]  CMD_BYTE_BITS   = 7'd8;
   localparam logic [6:0]  POLL_CMD_BITS   = 7'd24;
   localparam logic [6:0]  ID_REPLY_BITS   = 7'd24;
   localparam logic [6:0]  POLL_REPLY_BITS = 7'd64;

   typedef enum logic [2:0] {
      IDLE,
      RX,
      STOP,
      IGNORE,
      TURN,
      TX,
      TXSTOP
   } gc_state_e;

   // Replies are shifted out of bit 63, so the short identify word sits in
   // the top 24 bits.
   function automatic logic [63:0] reply_word(input logic        is_poll,
                                              input logic [63:0] pad);
      return is_poll ? pad : {ID_REPLY, 40'h0};
   endfunction

endpackage

// File: rtl/gc_line_sync.sv
// ---------------------------------------------------------------------------
// gc_line_sync
// Two-flop synchronizer for the asynchronous joybus line plus a falling-edge
// pulse. Resets to line-high (the idle bus level) so no false edge is seen
// when reset is released.
//   clk     : system clock
//   reset   : asynchronous, active-low reset
//   line_i  : raw joybus level
//   line_o  : synchronized line level (2 clk latency)
//   fall_o  : one-cycle pulse aligned with line_o going low
// ---------------------------------------------------------------------------
module gc_line_sync
   import gc_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic line_i,
   output logic line_o,
   output logic fall_o
);

   // [0] first stage, [1] second stage (synchronized), [2] previous value
   logic [2:0] sync_q;
   logic [2:0] sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], line_i};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= 3'b111;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign line_o = sync_q[1];
   assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/gc_pad_responder.sv
// ---------------------------------------------------------------------------
// gc_pad_responder
// Controller side of the GameCube single-wire joybus. Decodes console
// commands and answers identify (0x00) with 0x090000 and poll (0x40 xx yy)
// with the 64-bit pad state. The line is driven open-drain.
//   clk          : system clock
//   reset        : asynchronous, active-low reset
//   gc_in        : raw joybus line level (asynchronous to clk)
//   gc_drive_low : 1 = pull the line low, 0 = release
//   pad_state    : poll reply payload, MSB first
//   rumble       : bit 0 of the last accepted poll's third byte
//   busy         : high from the first command edge until the reply ends
//   poll_strobe  : one-cycle pulse when a poll reply is loaded
// ---------------------------------------------------------------------------
module gc_pad_responder
   import gc_pkg::*;
#(
   parameter int US_CYCLES  = 25,
   parameter int TURN_US    = 4,
   parameter int TIMEOUT_US = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        gc_in,
   output logic        gc_drive_low,
   input  logic [63:0] pad_state,
   output logic        rumble,
   output logic        busy,
   output logic        poll_strobe
);

   localparam int SLOT_CYC = 4 * US_CYCLES;
   localparam int TURN_CYC = TURN_US * US_CYCLES;
   localparam int CNT_MAX  = (SLOT_CYC > TURN_CYC) ? SLOT_CYC : TURN_CYC;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int TMO_CYC  = TIMEOUT_US * US_CYCLES;
   localparam int TMO_W    = $clog2(TMO_CYC + 1);

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(2 * US_CYCLES - 1);
   localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYC - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST   = CNT_W'(SLOT_CYC - 1);
   localparam logic [CNT_W-1:0] ONE_LOW     = CNT_W'(US_CYCLES);
   localparam logic [CNT_W-1:0] ZERO_LOW    = CNT_W'(3 * US_CYCLES);
   localparam logic [CNT_W-1:0] STOP_LOW    = CNT_W'(2 * US_CYCLES);
   localparam logic [CNT_W-1:0] STOP_LAST   = CNT_W'(2 * US_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_ONE     = TMO_W'(1);
   localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TMO_CYC - 1);

   logic line;
   logic fall;

   gc_line_sync u_line_sync (
      .clk    (clk),
      .reset  (reset),
      .line_i (gc_in),
      .line_o (line),
      .fall_o (fall)
   );

   gc_state_e         state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [TMO_W-1:0]  tmo_q,    tmo_d;
   logic [6:0]        bit_q,    bit_d;
   logic [6:0]        len_q,    len_d;
   logic [23:0]       cmd_q,    cmd_d;
   logic [63:0]       reply_q,  reply_d;
   logic              pend_q,   pend_d;
   logic              rumble_q, rumble_d;
   logic              strobe_q, strobe_d;
   logic              drive_q,  drive_d;
   logic              busy_q,   busy_d;

   logic [23:0]       cmd_shift;
   logic [6:0]        bit_inc;
   logic              is_poll;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      bit_d     = bit_q;
      len_d     = len_q;
      cmd_d     = cmd_q;
      reply_d   = reply_q;
      pend_d    = pend_q;
      rumble_d  = rumble_q;
      strobe_d  = 1'b0;
      drive_d   = 1'b0;
      busy_d    = 1'b0;
      cmd_shift = {cmd_q[22:0], line};
      bit_inc   = bit_q + 7'd1;
      // A stop bit only completes a poll once all 24 command bits are in.
      is_poll   = (bit_q == POLL_CMD_BITS) && (cmd_q[23:16] == CMD_POLL);

      case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = RX;
               cnt_d   = '0;
               tmo_d   = '0;
               bit_d   = '0;
               cmd_d   = '0;
               pend_d  = 1'b1;
            end
         end

         RX, STOP: begin
            if (fall) begin
               // Every falling edge opens a bit cell; sample it 2 us later.
               cnt_d  = '0;
               tmo_d  = '0;
               pend_d = 1'b1;
            end else begin
               if (line) begin
                  tmo_d = tmo_q + TMO_ONE;
               end
               if (pend_q) begin
                  cnt_d = cnt_q + CNT_ONE;
                  if (cnt_q == SAMPLE_LAST) begin
                     pend_d = 1'b0;
                     if (state_q == RX) begin
                        cmd_d = cmd_shift;
                        bit_d = bit_inc;
                        if (bit_inc == CMD_BYTE_BITS) begin
                           if (cmd_shift[7:0] == CMD_ID) begin
                              state_d = STOP;
                           end else if (cmd_shift[7:0] != CMD_POLL) begin
                              state_d = IGNORE;
                           end
                        end else if (bit_inc == POLL_CMD_BITS) begin
                           state_d = STOP;
                        end
                     end else if (line) begin
                        // Short low pulse: a valid console stop bit.
                        state_d  = TURN;
                        cnt_d    = '0;
                        reply_d  = reply_word(is_poll, pad_state);
                        len_d    = is_poll ? POLL_REPLY_BITS : ID_REPLY_BITS;
                        strobe_d = is_poll;
                        if (is_poll) begin
                           rumble_d = cmd_q[0];
                        end
                     end else begin
                        state_d = IGNORE;
                     end
                  end
               end
               if (line && (tmo_q == TMO_LAST)) begin
                  state_d = IDLE;
                  pend_d  = 1'b0;
               end
            end
         end

         IGNORE: begin
            if (fall) begin
               tmo_d = '0;
            end else if (line) begin
               if (tmo_q == TMO_LAST) begin
                  state_d = IDLE;
               end else begin
                  tmo_d = tmo_q + TMO_ONE;
               end
            end
         end

         TURN: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == TURN_LAST) begin
               state_d = TX;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end

         TX: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == SLOT_LAST) begin
               cnt_d   = '0;
               reply_d = {reply_q[62:0], 1'b0};
               if (bit_q == (len_q - 7'd1)) begin
                  state_d = TXSTOP;
               end else begin
                  bit_d = bit_inc;
               end
            end
         end

         TXSTOP: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == STOP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Line drive is registered from next-state values so it changes on the
      // same edge as the slot counter it depends on.
      case (state_d)
         TX:      drive_d = cnt_d < (reply_d[63] ? ONE_LOW : ZERO_LOW);
         TXSTOP:  drive_d = cnt_d < STOP_LOW;
         default: drive_d = 1'b0;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         tmo_q    <= '0;
         bit_q    <= '0;
         len_q    <= '0;
         cmd_q    <= '0;
         reply_q  <= '0;
         pend_q   <= 1'b0;
         rumble_q <= 1'b0;
         strobe_q <= 1'b0;
         drive_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tmo_q    <= tmo_d;
         bit_q    <= bit_d;
         len_q    <= len_d;
         cmd_q    <= cmd_d;
         reply_q  <= reply_d;
         pend_q   <= pend_d;
         rumble_q <= rumble_d;
         strobe_q <= strobe_d;
         drive_q  <= drive_d;
         busy_q   <= busy_d;
      end
   end

   assign gc_drive_low = drive_q;
   assign rumble       = rumble_q;
   assign busy         = busy_q;
   assign poll_strobe  = strobe_q;

endmodule

// File: tb/tb_gc_pad_responder.sv
// ---------------------------------------------------------------------------
// tb_gc_pad_responder
// Directed bench: a console model drives the joybus open-drain alongside the
// DUT, and a pulse-width decoder turns the DUT's drive back into bits.
// ---------------------------------------------------------------------------
module tb_gc_pad_responder;

   localparam int US   = 4;
   localparam logic [63:0] PAD_A = 64'h0080_8080_8080_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cons_low = 1'b0;
   logic [63:0] pad_state = '0;
   wire         gc_in;
   logic        gc_drive_low;
   logic        rumble;
   logic        busy;
   logic        poll_strobe;

   int n_checks = 0;
   int n_errors = 0;

   // Wired-AND bus: either side pulling low wins.
   assign gc_in = ~(cons_low | gc_drive_low);

   always #5 clk = ~clk;

   gc_pad_responder #(
      .US_CYCLES  (US),
      .TURN_US    (4),
      .TIMEOUT_US (64)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .gc_in        (gc_in),
      .gc_drive_low (gc_drive_low),
      .pad_state    (pad_state),
      .rumble       (rumble),
      .busy         (busy),
      .poll_strobe  (poll_strobe)
   );

   // Reply decoder: classify each low pulse of the DUT drive by width.
   int          run = 0;
   logic [63:0] rx_bits = '0;
   int          n_bits = 0, n_stops = 0, n_bad = 0, n_strobe = 0, n_drive = 0;
   int          b_bits, b_stops, b_bad, b_strobe, b_drive;

   always @(negedge clk) begin
      if (poll_strobe) n_strobe++;
      if (gc_drive_low) begin
         run++;
         n_drive++;
      end else if (run > 0) begin
         if (run == US) begin
            rx_bits = {rx_bits[62:0], 1'b1};
            n_bits++;
         end else if (run == 3 * US) begin
            rx_bits = {rx_bits[62:0], 1'b0};
            n_bits++;
         end else if (run == 2 * US) begin
            n_stops++;
         end else begin
            n_bad++;
         end
         run = 0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic snap();
      b_bits   = n_bits;
      b_stops  = n_stops;
      b_bad    = n_bad;
      b_strobe = n_strobe;
      b_drive  = n_drive;
   endtask

   // Must be entered just after a rising edge; leaves the same alignment.
   task automatic send_bit(input logic b);
      cons_low = 1'b1;
      repeat (b ? US : 3 * US) @(posedge clk);
      #1 cons_low = 1'b0;
      repeat (b ? 3 * US : US) @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [23:0] v, input int nbits, input bit with_stop);
      @(posedge clk);
      #1;
      for (int i = 0; i < nbits; i++) begin
         send_bit(v[nbits-1-i]);
      end
      if (with_stop) begin
         cons_low = 1'b1;
         repeat (US) @(posedge clk);
         #1 cons_low = 1'b0;
         repeat (3 * US) @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input int budget, output int cyc);
      cyc = 0;
      while (busy && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      // One more edge so the decoder has classified the final pulse.
      @(negedge clk);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int k;

      // Reset state
      repeat (5) @(posedge clk);
      #1;
      check("rst_drive",  64'(gc_drive_low), 64'd0);
      check("rst_busy",   64'(busy),         64'd0);
      check("rst_rumble", 64'(rumble),       64'd0);
      check("rst_strobe", 64'(poll_strobe),  64'd0);
      #3 reset = 1'b1;
      repeat (5) @(posedge clk);

      // Identify
      snap();
      send_cmd(24'h000000, 8, 1'b1);
      wait_idle(3000, c);
      check("id_busy",   64'(busy),               64'd0);
      check("id_nbits",  64'(n_bits - b_bits),     64'd24);
      check("id_value",  64'(rx_bits[23:0]),       64'h090000);
      check("id_stop",   64'(n_stops - b_stops),   64'd1);
      check("id_strobe", 64'(n_strobe - b_strobe), 64'd0);
      check("id_bad",    64'(n_bad - b_bad),       64'd0);

      // Poll with rumble on
      pad_state = PAD_A;
      snap();
      send_cmd(24'h400301, 24, 1'b1);
      wait_idle(3000, c);
      check("poll1_nbits",  64'(n_bits - b_bits),     64'd64);
      check("poll1_value",  rx_bits,                  PAD_A);
      check("poll1_rumble", 64'(rumble),              64'd1);
      check("poll1_strobe", 64'(n_strobe - b_strobe), 64'd1);
      check("poll1_stop",   64'(n_stops - b_stops),   64'd1);

      // Poll with rumble off, different payload
      pad_state = 64'h1234_5678_9ABC_DEF0;
      snap();
      send_cmd(24'h400300, 24, 1'b1);
      wait_idle(3000, c);
      check("poll2_value",  rx_bits,     64'h1234_5678_9ABC_DEF0);
      check("poll2_rumble", 64'(rumble), 64'd0);

      // Snapshot: payload changes one cycle after the strobe
      pad_state = PAD_A;
      snap();
      fork
         send_cmd(24'h400301, 24, 1'b1);
         begin
            k = 0;
            while (k < 3000 && !poll_strobe) begin
               @(negedge clk);
               k++;
            end
            @(posedge clk);
            #1 pad_state = '1;
         end
      join
      wait_idle(3000, c);
      check("snap_seen",   64'(k < 3000),  64'd1);
      check("snap_value",  rx_bits,        PAD_A);
      check("snap_rumble", 64'(rumble),    64'd1);
      pad_state = PAD_A;

      // Unknown command: silent, busy drops after the line-high timeout
      snap();
      send_cmd(24'h000041, 8, 1'b0);
      wait_idle(600, c);
      check("unk_busy",     64'(busy),                     64'd0);
      check("unk_window",   64'(c >= 200 && c <= 300),     64'd1);
      check("unk_no_drive", 64'(n_drive - b_drive),        64'd0);
      snap();
      send_cmd(24'h000000, 8, 1'b1);
      wait_idle(3000, c);
      check("unk_id_value", 64'(rx_bits[23:0]),   64'h090000);
      check("unk_id_nbits", 64'(n_bits - b_bits), 64'd24);

      // Truncated poll: 12 bits then silence
      snap();
      send_cmd(24'h000400, 12, 1'b0);
      wait_idle(600, c);
      check("trunc_busy",     64'(busy),                 64'd0);
      check("trunc_no_drive", 64'(n_drive - b_drive),    64'd0);
      check("trunc_rumble",   64'(rumble),               64'd1);
      check("trunc_strobe",   64'(n_strobe - b_strobe),  64'd0);

      // Reset in the middle of a reply, while the line is pulled low
      send_cmd(24'h400300, 24, 1'b1);
      k = 0;
      repeat (100) @(posedge clk);
      while (k < 2000 && !gc_drive_low) begin
         @(negedge clk);
         k++;
      end
      check("mid_drive_seen", 64'(k < 2000), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("mid_drive",  64'(gc_drive_low), 64'd0);
      check("mid_busy",   64'(busy),         64'd0);
      check("mid_rumble", 64'(rumble),       64'd0);
      check("mid_strobe", 64'(poll_strobe),  64'd0);
      #20 reset = 1'b1;
      repeat (5) @(posedge clk);

      // Poll after reset
      snap();
      send_cmd(24'h400301, 24, 1'b1);
      wait_idle(3000, c);
      check("post_nbits",  64'(n_bits - b_bits), 64'd64);
      check("post_value",  rx_bits,              PAD_A);
      check("post_rumble", 64'(rumble),          64'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
